serial_subtractor_16_bit: RTL and testbench

SERIAL_SUBTRACTOR_16_BIT -- requirements
Module: serial_subtractor_16_bit

---
 rtl/serial_subtractor_16_bit.sv | 110 +++++++++++
 tb/tb_serial_subtractor_16_bit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16_bit.sv
// Nibble-serial 16-bit subtractor: one reused 4-bit ripple-borrow slice,
// four cycles per operation, borrow carried between nibbles in a register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last result
// ST_RUN  | one nibble per cycle, LSB nibble first, cnt selects nibble
// ST_DONE | result valid, done pulses; start here re-enters ST_RUN
module serial_subtractor_16_bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] diff,
   output logic        bout,
   output logic        ovf
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t      state;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [1:0]  cnt;
   logic        borrow_q;

   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [3:0]  nib_d;
   logic        br_c;
   logic        nib_bout;
   logic        ovf_c;

   assign nib_a = a_q[{cnt, 2'b00} +: 4];
   assign nib_b = b_q[{cnt, 2'b00} +: 4];

   // four full-subtractor cells, borrow rippling LSB to MSB
   always_comb begin
      nib_d = 4'h0;
      br_c  = borrow_q;
      for (int i = 0; i < 4; i++) begin
         nib_d[i] = nib_a[i] ^ nib_b[i] ^ br_c;
         br_c     = (~nib_a[i] & nib_b[i]) | (~(nib_a[i] ^ nib_b[i]) & br_c);
      end
      nib_bout = br_c;
   end

   // only meaningful on the last nibble, where nib_d[3] is the result sign
   assign ovf_c = (a_q[15] != b_q[15]) && (nib_d[3] != a_q[15]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         cnt      <= 2'd0;
         borrow_q <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= 16'h0000;
         bout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt      <= 2'd0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               diff[{cnt, 2'b00} +: 4] <= nib_d;
               borrow_q                <= nib_bout;
               cnt                     <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  bout  <= nib_bout;
                  ovf   <= ovf_c;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt      <= 2'd0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_16_bit.sv
// Directed and random checks for serial_subtractor_16_bit; expected results
// are hand-computed constants or an independent arithmetic model.
module tb_serial_subtractor_16_bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        bin = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        bout;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   serial_subtractor_16_bit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE or DONE; the edge after the call ends
   // with done observed. Operands are scrambled after capture.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin, input logic [15:0] ed,
                         input logic eb, input logic eo, input string name);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      tick();
      start = 1'b0; a = ~ta; b = ta ^ tb; bin = ~tbin;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s capture: busy=%b done=%b want busy=1 done=0", name, busy, done);
      end
      for (int i = 1; i < 4; i++) begin
         tick();
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s run cyc%0d: busy=%b done=%b want busy=1 done=0", name, i, busy, done);
         end
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || bout !== eb || ovf !== eo) begin
         bad++;
         $display("FAIL %s result: done=%b busy=%b diff=%h bout=%b ovf=%b want done=1 busy=0 diff=%h bout=%b ovf=%b",
                  name, done, busy, diff, bout, ovf, ed, eb, eo);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 16'hABCD; b = 16'h1111; bin = 1'b1;
      tick();
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b want all zero", busy, done, diff, bout, ovf);
      end
      start = 1'b0;
   endtask

   task automatic test_first_op();
      // rst drops on the same cycle start is raised
      rst = 1'b0;
      run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic");
      tick();
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h1000 || bout !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL hold: busy=%b done=%b diff=%h bout=%b ovf=%b want 0 0 1000 0 0", busy, done, diff, bout, ovf);
      end
   endtask

   task automatic test_borrow_ovf();
      run_op(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, "xnibble");
      tick();
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "underflow");
      tick();
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "sovf");
      tick();
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "allones");
      tick();
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "posovf");
      tick();
   endtask

   task automatic test_ignore_start();
      int dones;
      a = 16'h5000; b = 16'h1000; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 16'h0001; b = 16'h0002; bin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) begin
            dones++;
            total++;
            if (i != 1 || diff !== 16'h4000 || bout !== 1'b0 || ovf !== 1'b0) begin
               bad++;
               $display("FAIL ignore result: cyc=%0d diff=%h bout=%b ovf=%b want cyc=1 diff=4000 bout=0 ovf=0", i, diff, bout, ovf);
            end
         end
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL ignore count: dones=%0d want 1", dones);
      end
   endtask

   task automatic test_back_to_back();
      run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, "b2b first");
      // start during the DONE cycle: no idle cycle expected
      run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, "b2b second");
      tick();
   endtask

   task automatic test_reset_abort();
      int dones;
      a = 16'h9999; b = 16'h1111; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1; start = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL abort: busy=%b done=%b diff=%h bout=%b ovf=%b want all zero", busy, done, diff, bout, ovf);
      end
      rst = 1'b0; start = 1'b0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL abort quiet: active cycles=%0d want 0", dones);
      end
      run_op(16'h0020, 16'h0008, 1'b1, 16'h0017, 1'b0, 1'b0, "after abort");
      tick();
   endtask

   task automatic test_random();
      logic [15:0] ra, rb, ed;
      logic        rbin, eb, eo;
      logic [16:0] wide;
      for (int n = 0; n < 10000; n++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbin = 1'($urandom);
         if (n % 97 == 0) rb = ra;
         wide = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
         ed   = wide[15:0];
         eb   = wide[16];
         eo   = (ra[15] != rb[15]) && (ed[15] != ra[15]);
         run_op(ra, rb, rbin, ed, eb, eo, "random");
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_first_op();
      test_borrow_ovf();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
